// File: rtl/vending_machine_param.sv
// Vending machine controller: accumulates nickel/dime/quarter credit, vends
// one item when credit reaches PRICE, then pays out change or refunds one
// nickel per cycle.
module vending_machine_param #(
    parameter int unsigned CREDIT_W = 4,
    parameter int unsigned PRICE    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nb,
    input  logic                db,
    input  logic                qb,
    input  logic                cancel,
    output logic                s,
    output logic                r,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // Headroom for credit plus the largest same-cycle coin sum (1+2+5).
    localparam int unsigned SUM_W = CREDIT_W + 4;
    localparam logic [SUM_W-1:0]    CREDIT_MAX = SUM_W'({CREDIT_W{1'b1}});
    localparam logic [SUM_W-1:0]    PRICE_S    = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C      = CREDIT_W'(1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2,
        REFUND = 2'd3
    } state_t;

    state_t           state;
    logic             any_coin;
    logic             cancel_ok;
    logic [SUM_W-1:0] coin_sum;
    logic [SUM_W-1:0] new_sum;

    // Coin value sum and prospective credit for the current cycle.
    always_comb begin
        any_coin  = nb | db | qb;
        coin_sum  = SUM_W'(nb) + SUM_W'({db, 1'b0}) + (qb ? SUM_W'(5) : '0);
        new_sum   = SUM_W'(credit) + coin_sum;
        cancel_ok = cancel && (credit != '0);
    end

    // State, credit and coin-reject register; cancel outranks coins in ACCUM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ACCUM;
            credit   <= '0;
            coin_rej <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (cancel_ok) begin
                        coin_rej <= any_coin;
                        state    <= REFUND;
                    end else if (new_sum > CREDIT_MAX) begin
                        coin_rej <= 1'b1;
                    end else begin
                        coin_rej <= 1'b0;
                        credit   <= new_sum[CREDIT_W-1:0];
                        if (new_sum >= PRICE_S) begin
                            state <= VEND;
                        end
                    end
                end
                VEND: begin
                    coin_rej <= any_coin;
                    credit   <= credit - PRICE_C;
                    state    <= (credit != PRICE_C) ? CHANGE : ACCUM;
                end
                CHANGE, REFUND: begin
                    coin_rej <= any_coin;
                    credit   <= credit - ONE_C;
                    if (credit == ONE_C) begin
                        state <= ACCUM;
                    end
                end
                default: begin
                    coin_rej <= 1'b0;
                    state    <= ACCUM;
                end
            endcase
        end
    end

    // Pulse outputs decoded purely from the state register.
    always_comb begin
        s    = (state == VEND);
        r    = (state == CHANGE) || (state == REFUND);
        busy = (state != ACCUM);
    end

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: two instances (PRICE=3 and PRICE=15) share
// stimulus and are compared every cycle against a credit/payout model, with
// directed scenarios pinning literal values.
module tb_vending_machine_param;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic nb = 1'b0, db = 1'b0, qb = 1'b0, cancel = 1'b0;

    logic          a_s, a_r, a_rej, a_busy;
    logic [CW-1:0] a_credit;
    logic          b_s, b_r, b_rej, b_busy;
    logic [CW-1:0] b_credit;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    vending_machine_param #(.CREDIT_W(CW), .PRICE(3)) dut3 (
        .clk(clk), .rst(rst), .nb(nb), .db(db), .qb(qb), .cancel(cancel),
        .s(a_s), .r(a_r), .coin_rej(a_rej), .credit(a_credit), .busy(a_busy)
    );

    vending_machine_param #(.CREDIT_W(CW), .PRICE(15)) dut15 (
        .clk(clk), .rst(rst), .nb(nb), .db(db), .qb(qb), .cancel(cancel),
        .s(b_s), .r(b_r), .coin_rej(b_rej), .credit(b_credit), .busy(b_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: credit, a pending-vend flag and a paying-out flag.
    int m_credit[2];
    bit m_vend[2];
    bit m_pay[2];
    bit m_rej[2];
    int m_price[2] = '{3, 15};

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input int i);
        int sum;
        int maxc;
        bit coin;
        maxc = (1 << CW) - 1;
        coin = nb | db | qb;
        sum  = (nb ? 1 : 0) + (db ? 2 : 0) + (qb ? 5 : 0);
        if (!rst) begin
            m_credit[i] = 0; m_vend[i] = 0; m_pay[i] = 0; m_rej[i] = 0;
        end else if (m_vend[i]) begin
            m_rej[i]    = coin;
            m_credit[i] = m_credit[i] - m_price[i];
            m_vend[i]   = 0;
            m_pay[i]    = (m_credit[i] > 0);
        end else if (m_pay[i]) begin
            m_rej[i]    = coin;
            m_credit[i] = m_credit[i] - 1;
            m_pay[i]    = (m_credit[i] > 0);
        end else if (cancel && m_credit[i] > 0) begin
            m_rej[i] = coin;
            m_pay[i] = 1;
        end else if (m_credit[i] + sum > maxc) begin
            m_rej[i] = 1;
        end else begin
            m_rej[i]    = 0;
            m_credit[i] = m_credit[i] + sum;
            m_vend[i]   = (m_credit[i] >= m_price[i]);
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("p3_s",      int'(a_s),      int'(m_vend[0]));
            check("p3_r",      int'(a_r),      int'(m_pay[0]));
            check("p3_rej",    int'(a_rej),    int'(m_rej[0]));
            check("p3_credit", int'(a_credit), m_credit[0]);
            check("p3_busy",   int'(a_busy),   int'(m_vend[0] | m_pay[0]));
            check("p3_s_and_r", int'(a_s & a_r), 0);
            check("p15_s",      int'(b_s),      int'(m_vend[1]));
            check("p15_r",      int'(b_r),      int'(m_pay[1]));
            check("p15_rej",    int'(b_rej),    int'(m_rej[1]));
            check("p15_credit", int'(b_credit), m_credit[1]);
            check("p15_busy",   int'(b_busy),   int'(m_vend[1] | m_pay[1]));
        end
    end

    task automatic apply(input logic n, input logic d, input logic q, input logic c);
        nb = n; db = d; qb = q; cancel = c;
        @(posedge clk); #1;
        nb = 1'b0; db = 1'b0; qb = 1'b0; cancel = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1; rst = 1'b1; chk_en = 1'b1;
        @(negedge clk);
        check("rst_credit", int'(a_credit), 0);
        check("rst_busy",   int'(a_busy), 0);
        check("rst_rej",    int'(a_rej), 0);

        // nickel then dime: credit 1, then vend with no change
        do_reset();
        apply(1, 0, 0, 0);
        @(negedge clk); check("nd_credit1", int'(a_credit), 1);
        idle(1);
        apply(0, 1, 0, 0);
        @(negedge clk); check("nd_s", int'(a_s), 1); check("nd_credit3", int'(a_credit), 3);
        @(negedge clk); check("nd_credit0", int'(a_credit), 0); check("nd_r", int'(a_r), 0);
        check("nd_busy", int'(a_busy), 0);

        // quarter: vend then two change pulses
        do_reset();
        apply(0, 0, 1, 0);
        @(negedge clk); check("q_s", int'(a_s), 1); check("q_credit5", int'(a_credit), 5);
        @(negedge clk); check("q_r1", int'(a_r), 1); check("q_credit2", int'(a_credit), 2);
        @(negedge clk); check("q_r2", int'(a_r), 1); check("q_credit1", int'(a_credit), 1);
        @(negedge clk); check("q_r_end", int'(a_r), 0); check("q_credit0", int'(a_credit), 0);

        // dime then cancel: refund 2; cancel at zero credit ignored
        do_reset();
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 1);
        @(negedge clk); check("c_r1", int'(a_r), 1); check("c_s", int'(a_s), 0);
        @(negedge clk); check("c_r2", int'(a_r), 1);
        @(negedge clk); check("c_r_end", int'(a_r), 0); check("c_credit0", int'(a_credit), 0);
        apply(0, 0, 0, 1);
        @(negedge clk); check("c0_busy", int'(a_busy), 0); check("c0_r", int'(a_r), 0);

        // coin during change is rejected, change count unchanged
        do_reset();
        apply(0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk); check("qc_credit2", int'(a_credit), 2);
        apply(0, 1, 0, 0);
        @(negedge clk); check("qc_rej", int'(a_rej), 1); check("qc_r", int'(a_r), 1);
        check("qc_credit1", int'(a_credit), 1);
        @(negedge clk); check("qc_r_end", int'(a_r), 0); check("qc_credit0", int'(a_credit), 0);

        // nickel and cancel together: cancel wins, coin rejected
        do_reset();
        apply(0, 1, 0, 0);
        apply(1, 0, 0, 1);
        @(negedge clk); check("nc_rej", int'(a_rej), 1); check("nc_r", int'(a_r), 1);
        check("nc_credit2", int'(a_credit), 2);
        @(negedge clk); check("nc_r2", int'(a_r), 1);
        @(negedge clk); check("nc_r_end", int'(a_r), 0); check("nc_credit0", int'(a_credit), 0);

        // PRICE=15 overflow rejection then exact vend
        do_reset();
        apply(0, 0, 1, 0); apply(0, 0, 1, 0); apply(0, 1, 0, 0); apply(0, 1, 0, 0);
        @(negedge clk); check("p15_credit14", int'(b_credit), 14); check("p15_idle", int'(b_busy), 0);
        apply(0, 1, 0, 0);
        @(negedge clk); check("p15_ovf_rej", int'(b_rej), 1); check("p15_ovf_credit", int'(b_credit), 14);
        apply(1, 0, 0, 0);
        @(negedge clk); check("p15_vend_s", int'(b_s), 1); check("p15_credit15", int'(b_credit), 15);
        @(negedge clk); check("p15_after", int'(b_credit), 0); check("p15_after_busy", int'(b_busy), 0);

        // reset in the middle of change
        do_reset();
        apply(0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk); check("rc_r", int'(a_r), 1);
        rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); check("rc_credit", int'(a_credit), 0); check("rc_r0", int'(a_r), 0);
        check("rc_busy", int'(a_busy), 0);
        apply(1, 0, 0, 0);
        @(negedge clk); check("rc_nb", int'(a_credit), 1);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            nb     = ($urandom_range(0, 3) == 0);
            db     = ($urandom_range(0, 4) == 0);
            qb     = ($urandom_range(0, 7) == 0);
            cancel = ($urandom_range(0, 9) == 0);
            rst    = ($urandom_range(0, 149) != 0);
            @(posedge clk); #1;
        end
        nb = 0; db = 0; qb = 0; cancel = 0; rst = 1'b1;
        idle(20);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
